uart_rx_fifo: RTL and testbench

- Downstream stage of the UART receiver. Consumes the receiver's byte handshake (rx_data/rx_data_valid/host_ready) and its status (framing_err, overrun).
- Buffers received bytes in a DEPTH-entry circular FIFO. Each byte is tagged with a per-byte framing-error bit.
- Presents a show-ahead valid/ready pop interface, occupancy count and sticky overrun/drop status to the host/bus side.

---
 rtl/uart_rx_fifo.sv | 90 +++++++++
 tb/tb_uart_rx_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for the UART: buffers received bytes with a framing-error tag and
// presents a show-ahead valid/ready pop interface with occupancy and sticky overrun status.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_data_valid,
  input  logic          rx_framing_err,
  input  logic          rx_overrun,
  output logic          host_ready,
  output logic          clear_framing_err,
  output logic [7:0]    dout,
  output logic          dout_ferr,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [AW:0]   count,
  output logic          overrun_sticky,
  input  logic          clear_status
);

  localparam logic [AW:0] CountFull = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic [8:0]     mem [DEPTH];
  logic           overrun_q;
  logic           push, pop;

  // Flow control decodes from the registered state only, never from rx_data_valid.
  assign host_ready = rst_n && (state_q != StFull);
  assign dout_valid = rst_n && (state_q != StEmpty);

  assign push = rx_data_valid && host_ready;
  assign pop  = dout_ready && dout_valid;

  // The tag just stored covers every framing error since the previous push.
  assign clear_framing_err = push;

  assign count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (push && !pop) state_d = StPartial;
      end
      StPartial: begin
        if (count_d == CountFull)      state_d = StFull;
        else if (count_d == '0)        state_d = StEmpty;
      end
      StFull: begin
        if (pop && !push) state_d = StPartial;
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // Set wins over clear.
      if (rx_overrun)        overrun_q <= 1'b1;
      else if (clear_status) overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {rx_framing_err, rx_data};
  end

  assign {dout_ferr, dout} = mem[rd_ptr_q];
  assign count             = count_q;
  assign overrun_sticky    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16). Inputs change just after the
// falling edge; outputs are sampled there, away from the rising edge.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_data_valid;
  logic          rx_framing_err;
  logic          rx_overrun;
  logic          host_ready;
  logic          clear_framing_err;
  logic [7:0]    dout;
  logic          dout_ferr;
  logic          dout_valid;
  logic          dout_ready;
  logic [AW:0]   count;
  logic          overrun_sticky;
  logic          clear_status;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_data           (rx_data),
    .rx_data_valid     (rx_data_valid),
    .rx_framing_err    (rx_framing_err),
    .rx_overrun        (rx_overrun),
    .host_ready        (host_ready),
    .clear_framing_err (clear_framing_err),
    .dout              (dout),
    .dout_ferr         (dout_ferr),
    .dout_valid        (dout_valid),
    .dout_ready        (dout_ready),
    .count             (count),
    .overrun_sticky    (overrun_sticky),
    .clear_status      (clear_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    rx_data        = 8'h00;
    rx_data_valid  = 1'b0;
    rx_framing_err = 1'b0;
    rx_overrun     = 1'b0;
    dout_ready     = 1'b0;
    clear_status   = 1'b0;

    // Reset, then idle
    tick();
    tick();
    check_eq("rst_host_ready", 32'(host_ready), 0);
    check_eq("rst_dout_valid", 32'(dout_valid), 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_count", 32'(count), 0);
    check_eq("idle_dout_valid", 32'(dout_valid), 0);
    check_eq("idle_host_ready", 32'(host_ready), 1);
    check_eq("idle_overrun", 32'(overrun_sticky), 0);

    // Two pushes with framing tags, then one pop
    rx_data = 8'hA5; rx_framing_err = 1'b0; rx_data_valid = 1'b1;
    #1 check_eq("cfe_push0", 32'(clear_framing_err), 1);
    tick();
    rx_data = 8'h3C; rx_framing_err = 1'b1;
    #1 check_eq("cfe_push1", 32'(clear_framing_err), 1);
    tick();
    rx_data_valid = 1'b0; rx_framing_err = 1'b0;
    #1 check_eq("cfe_idle", 32'(clear_framing_err), 0);
    check_eq("two_count", 32'(count), 2);
    check_eq("two_dout", 32'(dout), 32'hA5);
    check_eq("two_ferr", 32'(dout_ferr), 0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check_eq("pop1_dout", 32'(dout), 32'h3C);
    check_eq("pop1_ferr", 32'(dout_ferr), 1);
    check_eq("pop1_count", 32'(count), 1);

    // Mid-operation reset discards stored bytes
    rx_data = 8'hEE; rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    check_eq("pre_rst_count", 32'(count), 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("mid_rst_count", 32'(count), 0);
    check_eq("mid_rst_valid", 32'(dout_valid), 0);

    // Fill to DEPTH with 0x00..0x0F
    rx_data_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(i);
      tick();
    end
    rx_data = 8'hFF;
    check_eq("full_host_ready", 32'(host_ready), 0);
    check_eq("full_count", 32'(count), 16);
    check_eq("full_no_cfe", 32'(clear_framing_err), 0);
    tick();
    check_eq("full_held_count", 32'(count), 16);
    check_eq("full_head", 32'(dout), 32'h00);
    rx_data_valid = 1'b0;
    dout_ready    = 1'b1;
    tick();
    dout_ready = 1'b0;
    check_eq("after_pop_ready", 32'(host_ready), 1);
    check_eq("after_pop_count", 32'(count), 15);
    rx_data = 8'h10; rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    check_eq("wrap_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_valid", 32'(dout_valid), 1);
      check_eq("drain_data", 32'(dout), 32'(i + 1));
      dout_ready = 1'b1;
      tick();
    end
    dout_ready = 1'b0;
    check_eq("drain_count", 32'(count), 0);
    check_eq("drain_empty", 32'(dout_valid), 0);

    // Steady push+pop at count=5
    rx_data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'(8'h20 + i);
      tick();
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rx_data = 8'(8'h25 + i);
      #1 check_eq("stream_data", 32'(dout), 32'(8'h20 + i));
      tick();
      check_eq("stream_count", 32'(count), 5);
    end
    rx_data_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("tail_data", 32'(dout), 32'(8'h2A + i));
      tick();
    end
    dout_ready = 1'b0;
    check_eq("tail_count", 32'(count), 0);

    // Push into empty with dout_ready already high
    rx_data = 8'h77; rx_data_valid = 1'b1; dout_ready = 1'b1;
    #1 check_eq("bypass_valid0", 32'(dout_valid), 0);
    tick();
    rx_data_valid = 1'b0; dout_ready = 1'b0;
    check_eq("bypass_valid1", 32'(dout_valid), 1);
    check_eq("bypass_dout", 32'(dout), 32'h77);
    check_eq("bypass_count", 32'(count), 1);

    // Sticky overrun
    rx_overrun = 1'b1;
    tick();
    tick();
    tick();
    check_eq("ovr_set", 32'(overrun_sticky), 1);
    clear_status = 1'b1;
    tick();
    check_eq("ovr_set_wins", 32'(overrun_sticky), 1);
    clear_status = 1'b0; rx_overrun = 1'b0;
    tick();
    check_eq("ovr_holds", 32'(overrun_sticky), 1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check_eq("ovr_cleared", 32'(overrun_sticky), 0);
    check_eq("ovr_keeps_data", 32'(count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
